// File: rtl/gpu_bg_reader_pkg.sv
// Shared GPU definitions for the background-pixel fetch path: pixel-pair
// layout, word unpacking and the VRAM word-address width.
package gpu_bg_reader_pkg;

    localparam int VRAM_ADDR_W = 18;

    typedef struct packed {
        logic       msk;
        logic [4:0] b;
        logic [4:0] g;
        logic [4:0] r;
    } bgPix_t;

    typedef struct packed {
        bgPix_t right;
        bgPix_t left;
    } bgPair_t;

    typedef enum logic {
        MEM_IDLE     = 1'b0,
        MEM_WAIT_ACK = 1'b1
    } memState_t;

    // Left pixel lives in the low halfword, right pixel in the high halfword.
    function automatic bgPair_t unpackPair(input logic [31:0] word);
        bgPair_t pair;
        pair.left.r  = word[4:0];
        pair.left.g  = word[9:5];
        pair.left.b  = word[14:10];
        pair.left.msk = word[15];
        pair.right.r = word[20:16];
        pair.right.g = word[25:21];
        pair.right.b = word[30:26];
        pair.right.msk = word[31];
        return pair;
    endfunction

endpackage

// File: rtl/gpu_idx_fifo.sv
// Small synchronous FIFO of slot indices; remembers which result slots are
// still waiting for a VRAM read beat, in request order.
module gpu_idx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             i_nrst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_pushIdx,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_headIdx,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] idxMem [DEPTH];
    logic [PTR_W-1:0] wrPtrReg;
    logic [PTR_W-1:0] rdPtrReg;
    logic [PTR_W:0]   countReg;

    assign o_headIdx = idxMem[rdPtrReg];
    assign o_empty   = (countReg == '0);

    always_ff @(posedge clk) begin
        if (i_push) begin
            idxMem[wrPtrReg] <= i_pushIdx;
        end
    end

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (i_push) begin
                wrPtrReg <= wrPtrReg + PTR_W'(1);
            end
            if (i_pop) begin
                rdPtrReg <= rdPtrReg + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   countReg <= countReg + (PTR_W+1)'(1);
                2'b01:   countReg <= countReg - (PTR_W+1)'(1);
                default: countReg <= countReg;
            endcase
        end
    end

endmodule

// File: rtl/gpu_bg_reader.sv
// Background-pixel fetch unit: issues one VRAM word read per pixel pair that
// needs a background, reorders nothing, and hands pairs to the blend stage.
module gpu_bg_reader
    import gpu_bg_reader_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = VRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              i_nrst,
    input  logic              i_reqValid,
    output logic              o_reqReady,
    input  logic [9:0]        i_scrX_Mul2,
    input  logic [8:0]        i_scrY,
    input  logic              i_needBG,
    output logic              o_memRead,
    output logic [ADDR_W-1:0] o_memAdr,
    input  logic              i_memAck,
    input  logic              i_memDataValid,
    input  logic [31:0]       i_memData,
    output logic              o_bgValid,
    input  logic              i_bgReady,
    output logic [4:0]        o_rBG_L,
    output logic [4:0]        o_gBG_L,
    output logic [4:0]        o_bBG_L,
    output logic [4:0]        o_rBG_R,
    output logic [4:0]        o_gBG_R,
    output logic [4:0]        o_bBG_R,
    output logic              o_bgMskL,
    output logic              o_bgMskR
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

    memState_t         stateReg, stateNext;
    logic [ADDR_W-1:0] memAdrReg, memAdrNext;
    logic [ADDR_W-1:0] reqAdr;

    logic [31:0]      slotData [FIFO_DEPTH];
    logic             slotDone [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtrReg;
    logic [PTR_W-1:0] rdPtrReg;
    logic [PTR_W:0]   countReg;
    logic             runReg;

    logic             accept;
    logic             allocRead;
    logic             popOut;
    logic             beatTake;
    logic [PTR_W-1:0] pendHead;
    logic             pendEmpty;
    bgPair_t          headPair;

    // Shifting the concatenation drops the ignored X bit0 and yields {Y, X[9:1]}.
    assign reqAdr = ADDR_W'({i_scrY, i_scrX_Mul2} >> 1);

    // runReg keeps ready low during the first cycle out of reset.
    assign o_reqReady = runReg && (countReg < DEPTH_CNT) && (stateReg == MEM_IDLE);
    assign accept     = i_reqValid && o_reqReady;
    assign allocRead  = accept && i_needBG;
    assign o_bgValid  = slotDone[rdPtrReg];
    assign popOut     = o_bgValid && i_bgReady;
    assign beatTake   = i_memDataValid && !pendEmpty;

    assign o_memRead = (stateReg == MEM_WAIT_ACK);
    assign o_memAdr  = memAdrReg;

    always_comb begin
        stateNext  = stateReg;
        memAdrNext = memAdrReg;
        case (stateReg)
            MEM_IDLE: begin
                if (allocRead) begin
                    stateNext  = MEM_WAIT_ACK;
                    memAdrNext = reqAdr;
                end
            end
            MEM_WAIT_ACK: begin
                if (i_memAck) begin
                    stateNext = MEM_IDLE;
                end
            end
            default: stateNext = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            stateReg  <= MEM_IDLE;
            memAdrReg <= '0;
            runReg    <= 1'b0;
        end else begin
            stateReg  <= stateNext;
            memAdrReg <= memAdrNext;
            runReg    <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (accept) begin
                wrPtrReg <= wrPtrReg + PTR_W'(1);
            end
            if (popOut) begin
                rdPtrReg <= rdPtrReg + PTR_W'(1);
            end
            case ({accept, popOut})
                2'b10:   countReg <= countReg + (PTR_W+1)'(1);
                2'b01:   countReg <= countReg - (PTR_W+1)'(1);
                default: countReg <= countReg;
            endcase
        end
    end

    // A slot is never allocated, filled and popped in the same cycle, so the
    // priority order below only matters for clarity.
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk or negedge i_nrst) begin
                if (!i_nrst) begin
                    slotData[gi] <= '0;
                    slotDone[gi] <= 1'b0;
                end else if (accept && (wrPtrReg == PTR_W'(gi))) begin
                    slotData[gi] <= '0;
                    slotDone[gi] <= !i_needBG;
                end else if (beatTake && (pendHead == PTR_W'(gi))) begin
                    slotData[gi] <= i_memData;
                    slotDone[gi] <= 1'b1;
                end else if (popOut && (rdPtrReg == PTR_W'(gi))) begin
                    slotData[gi] <= '0;
                    slotDone[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    gpu_idx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PTR_W)
    ) u_pendFifo (
        .clk       (clk),
        .i_nrst    (i_nrst),
        .i_push    (allocRead),
        .i_pushIdx (wrPtrReg),
        .i_pop     (beatTake),
        .o_headIdx (pendHead),
        .o_empty   (pendEmpty)
    );

    assign headPair = unpackPair(slotData[rdPtrReg]);

    assign o_rBG_L  = headPair.left.r;
    assign o_gBG_L  = headPair.left.g;
    assign o_bBG_L  = headPair.left.b;
    assign o_bgMskL = headPair.left.msk;
    assign o_rBG_R  = headPair.right.r;
    assign o_gBG_R  = headPair.right.g;
    assign o_bBG_R  = headPair.right.b;
    assign o_bgMskR = headPair.right.msk;

endmodule

// File: tb/tb_gpu_bg_reader.sv
// Directed and randomized bench for gpu_bg_reader; expected pairs come from a
// request-order queue and a synthetic VRAM content function.
module tb_gpu_bg_reader;

    localparam int N_RAND = 80;

    logic        clk;
    logic        i_nrst;
    logic        i_reqValid;
    logic        o_reqReady;
    logic [9:0]  i_scrX_Mul2;
    logic [8:0]  i_scrY;
    logic        i_needBG;
    logic        o_memRead;
    logic [17:0] o_memAdr;
    logic        i_memAck;
    logic        i_memDataValid;
    logic [31:0] i_memData;
    logic        o_bgValid;
    logic        i_bgReady;
    logic [4:0]  o_rBG_L, o_gBG_L, o_bBG_L;
    logic [4:0]  o_rBG_R, o_gBG_R, o_bBG_R;
    logic        o_bgMskL, o_bgMskR;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] expQ[$];
    logic [31:0] beatQ[$];
    bit          consDone = 0;
    logic [31:0] obsWord;

    assign obsWord = {o_bgMskR, o_bBG_R, o_gBG_R, o_rBG_R,
                      o_bgMskL, o_bBG_L, o_gBG_L, o_rBG_L};

    gpu_bg_reader #(
        .FIFO_DEPTH (4),
        .ADDR_W     (18)
    ) dut (
        .clk            (clk),
        .i_nrst         (i_nrst),
        .i_reqValid     (i_reqValid),
        .o_reqReady     (o_reqReady),
        .i_scrX_Mul2    (i_scrX_Mul2),
        .i_scrY         (i_scrY),
        .i_needBG       (i_needBG),
        .o_memRead      (o_memRead),
        .o_memAdr       (o_memAdr),
        .i_memAck       (i_memAck),
        .i_memDataValid (i_memDataValid),
        .i_memData      (i_memData),
        .o_bgValid      (o_bgValid),
        .i_bgReady      (i_bgReady),
        .o_rBG_L        (o_rBG_L),
        .o_gBG_L        (o_gBG_L),
        .o_bBG_L        (o_bBG_L),
        .o_rBG_R        (o_rBG_R),
        .o_gBG_R        (o_gBG_R),
        .o_bBG_R        (o_bBG_R),
        .o_bgMskL       (o_bgMskL),
        .o_bgMskR       (o_bgMskR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synthetic VRAM contents: every word address holds a distinct pattern.
    function automatic logic [31:0] memWord(input logic [17:0] adr);
        return ({14'd0, adr} * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [17:0] pairAdr(input logic [9:0] x, input logic [8:0] y);
        logic [8:0] xw;
        xw = x[9:1];
        return {y, xw};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic missed(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=no-event expected=event", tag);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the request until accepted; the expected pair is queued just
    // before the accepting edge so no consumer can see it early.
    task automatic sendReq(input logic [9:0] x, input logic [8:0] y, input logic nbg);
        i_reqValid  = 1'b1;
        i_scrX_Mul2 = x;
        i_scrY      = y;
        i_needBG    = nbg;
        for (int c = 0; c < 300; c++) begin
            if (o_reqReady) begin
                expQ.push_back(nbg ? memWord(pairAdr(x, y)) : 32'd0);
                step();
                i_reqValid = 1'b0;
                return;
            end
            step();
        end
        i_reqValid = 1'b0;
        missed("req_accept");
    endtask

    task automatic ackOne(input string tag);
        for (int c = 0; c < 50; c++) begin
            if (o_memRead) begin
                i_memAck = 1'b1;
                step();
                i_memAck = 1'b0;
                return;
            end
            step();
        end
        missed(tag);
    endtask

    task automatic beat(input logic [31:0] data);
        i_memDataValid = 1'b1;
        i_memData      = data;
        step();
        i_memDataValid = 1'b0;
    endtask

    task automatic popCheck(input string tag, input logic [31:0] exp);
        for (int c = 0; c < 50; c++) begin
            if (o_bgValid) begin
                chk(tag, obsWord, exp);
                i_bgReady = 1'b1;
                step();
                i_bgReady = 1'b0;
                return;
            end
            step();
        end
        missed(tag);
    endtask

    initial begin
        logic [9:0]  rx;
        logic [8:0]  ry;
        logic        rn;
        logic [17:0] adrA, adrB, adrC;

        i_nrst = 1'b0; i_reqValid = 1'b0; i_scrX_Mul2 = '0; i_scrY = '0;
        i_needBG = 1'b0; i_memAck = 1'b0; i_memDataValid = 1'b0;
        i_memData = '0; i_bgReady = 1'b0;

        // Reset state
        step(); step();
        chk("rst_reqReady", {31'd0, o_reqReady}, 32'd0);
        chk("rst_memRead", {31'd0, o_memRead}, 32'd0);
        chk("rst_memAdr", {14'd0, o_memAdr}, 32'd0);
        chk("rst_bgValid", {31'd0, o_bgValid}, 32'd0);
        chk("rst_pair", obsWord, 32'd0);
        i_nrst = 1'b1;
        step();
        chk("ready_after_rst", {31'd0, o_reqReady}, 32'd1);

        // Single read, held without ack
        sendReq(10'h0A6, 9'h045, 1'b1);
        chk("single_memRead", {31'd0, o_memRead}, 32'd1);
        chk("single_memAdr", {14'd0, o_memAdr}, 32'h08A53);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_memRead", {31'd0, o_memRead}, 32'd1);
            chk("hold_memAdr", {14'd0, o_memAdr}, 32'h08A53);
            chk("hold_reqReady", {31'd0, o_reqReady}, 32'd0);
        end
        i_memAck = 1'b1;
        step();
        i_memAck = 1'b0;
        chk("ack_memRead", {31'd0, o_memRead}, 32'd0);
        chk("ack_reqReady", {31'd0, o_reqReady}, 32'd1);
        chk("pre_beat_valid", {31'd0, o_bgValid}, 32'd0);
        beat(32'h8421_7FFF);
        chk("beat_valid", {31'd0, o_bgValid}, 32'd1);
        chk("single_rL", {27'd0, o_rBG_L}, 32'd31);
        chk("single_gL", {27'd0, o_gBG_L}, 32'd31);
        chk("single_bL", {27'd0, o_bBG_L}, 32'd31);
        chk("single_mskL", {31'd0, o_bgMskL}, 32'd0);
        chk("single_rR", {27'd0, o_rBG_R}, 32'd1);
        chk("single_gR", {27'd0, o_gBG_R}, 32'd1);
        chk("single_bR", {27'd0, o_bBG_R}, 32'd1);
        chk("single_mskR", {31'd0, o_bgMskR}, 32'd1);
        i_bgReady = 1'b1;
        step();
        i_bgReady = 1'b0;
        chk("single_popped", {31'd0, o_bgValid}, 32'd0);

        // Four zero-background requests fill the buffer
        for (int k = 0; k < 4; k++) begin
            sendReq(10'(k * 2), 9'd0, 1'b0);
            chk("nobg_visible", {31'd0, o_bgValid}, 32'd1);
        end
        chk("nobg_full_ready", {31'd0, o_reqReady}, 32'd0);
        for (int k = 0; k < 4; k++) popCheck("nobg_pop", 32'd0);
        chk("nobg_empty", {31'd0, o_bgValid}, 32'd0);
        chk("nobg_ready_back", {31'd0, o_reqReady}, 32'd1);

        // Mixed order: read A, no-BG, read B
        adrA = pairAdr(10'h010, 9'h001);
        adrB = pairAdr(10'h3FF, 9'h1FF);
        sendReq(10'h010, 9'h001, 1'b1);
        ackOne("mixed_ackA");
        sendReq(10'h155, 9'h0AA, 1'b0);
        sendReq(10'h3FF, 9'h1FF, 1'b1);
        chk("mixed_adrB", {14'd0, o_memAdr}, {14'd0, adrB});
        ackOne("mixed_ackB");
        repeat (5) step();
        chk("mixed_wait_A", {31'd0, o_bgValid}, 32'd0);
        beat(memWord(adrA));
        popCheck("mixed_A", memWord(adrA));
        popCheck("mixed_zero", 32'd0);
        repeat (5) step();
        chk("mixed_wait_B", {31'd0, o_bgValid}, 32'd0);
        beat(memWord(adrB));
        popCheck("mixed_B", memWord(adrB));
        chk("mixed_empty", {31'd0, o_bgValid}, 32'd0);

        // Full buffer: pop and request in the same cycle
        for (int k = 0; k < 4; k++) sendReq(10'd4, 9'd4, 1'b0);
        i_reqValid = 1'b1; i_needBG = 1'b0; i_bgReady = 1'b1;
        chk("full_pop_ready", {31'd0, o_reqReady}, 32'd0);
        chk("full_pop_valid", {31'd0, o_bgValid}, 32'd1);
        step();
        i_bgReady = 1'b0;
        chk("full_next_ready", {31'd0, o_reqReady}, 32'd1);
        step();
        i_reqValid = 1'b0;
        chk("full_again", {31'd0, o_reqReady}, 32'd0);
        for (int k = 0; k < 4; k++) popCheck("full_drain", 32'd0);
        step();
        chk("full_no_dup", {31'd0, o_bgValid}, 32'd0);

        // Spurious data beats
        beat(32'hDEAD_BEEF);
        chk("spur_valid", {31'd0, o_bgValid}, 32'd0);
        chk("spur_pair", obsWord, 32'd0);
        for (int k = 0; k < 3; k++) sendReq(10'd8, 9'd8, 1'b0);
        beat(32'hCAFE_F00D);
        chk("spur_ready", {31'd0, o_reqReady}, 32'd1);
        sendReq(10'd8, 9'd8, 1'b0);
        chk("spur_count", {31'd0, o_reqReady}, 32'd0);
        for (int k = 0; k < 4; k++) popCheck("spur_drain", 32'd0);
        chk("spur_empty", {31'd0, o_bgValid}, 32'd0);

        // Reset while a read is waiting for ack
        adrC = pairAdr(10'h100, 9'h080);
        sendReq(10'h002, 9'h002, 1'b0);
        sendReq(10'h100, 9'h080, 1'b1);
        chk("mid_memRead", {31'd0, o_memRead}, 32'd1);
        chk("mid_valid", {31'd0, o_bgValid}, 32'd1);
        #2;
        i_nrst = 1'b0;
        #1;
        chk("mid_rst_memRead", {31'd0, o_memRead}, 32'd0);
        chk("mid_rst_memAdr", {14'd0, o_memAdr}, 32'd0);
        chk("mid_rst_valid", {31'd0, o_bgValid}, 32'd0);
        chk("mid_rst_pair", obsWord, 32'd0);
        chk("mid_rst_ready", {31'd0, o_reqReady}, 32'd0);
        step();
        i_nrst = 1'b1;
        step();
        beat(memWord(adrC));
        chk("stale_dropped", {31'd0, o_bgValid}, 32'd0);
        chk("post_rst_ready", {31'd0, o_reqReady}, 32'd1);
        adrC = pairAdr(10'h2A4, 9'h033);
        sendReq(10'h2A4, 9'h033, 1'b1);
        chk("post_rst_adr", {14'd0, o_memAdr}, {14'd0, adrC});
        ackOne("post_rst_ack");
        beat(memWord(adrC));
        popCheck("post_rst_pair", memWord(adrC));

        // Randomized traffic against the request-order queue
        expQ.delete();
        beatQ.delete();
        fork
            begin
                for (int n = 0; n < N_RAND; n++) begin
                    if ($urandom_range(0, 3) == 0) step();
                    rx = 10'($urandom_range(0, 1023));
                    ry = 9'($urandom_range(0, 511));
                    rn = 1'($urandom_range(0, 1));
                    sendReq(rx, ry, rn);
                end
            end
            begin
                for (int c = 0; c < 20000 && !consDone; c++) begin
                    if (beatQ.size() > 0 && $urandom_range(0, 2) != 0) begin
                        i_memDataValid = 1'b1;
                        i_memData      = beatQ.pop_front();
                    end else begin
                        i_memDataValid = 1'b0;
                    end
                    if (o_memRead && $urandom_range(0, 1) == 1) begin
                        i_memAck = 1'b1;
                        beatQ.push_back(memWord(o_memAdr));
                    end else begin
                        i_memAck = 1'b0;
                    end
                    step();
                end
                i_memDataValid = 1'b0;
                i_memAck       = 1'b0;
            end
            begin
                int popped;
                popped = 0;
                for (int c = 0; c < 20000 && popped < N_RAND; c++) begin
                    if (o_bgValid && $urandom_range(0, 3) != 0) begin
                        if (expQ.size() == 0) missed("rand_unexpected");
                        else chk("rand_pair", obsWord, expQ.pop_front());
                        i_bgReady = 1'b1;
                        popped++;
                    end else begin
                        i_bgReady = 1'b0;
                    end
                    step();
                end
                i_bgReady = 1'b0;
                if (popped < N_RAND) missed("rand_drain");
                consDone = 1'b1;
            end
        join
        step();
        chk("rand_final_empty", {31'd0, o_bgValid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpu_bg_reader.md
Name: gpu_bg_reader

Overview:
Background-pixel fetch unit for the GPU pixel write pipeline: the read side of the 32-bit pixel-pair path that feeds the compute/blend stage.
- Accepts pixel-pair coordinates and issues one 32-bit VRAM word read per pair when the background is needed.
- Buffers returned words in order and unpacks each word into two 5:5:5+mask background pixels.
- Delivers the pixel pairs to the blend stage over a valid/ready handshake.

Parameters:
FIFO_DEPTH, 4, entries in result buffer (power of 2, >=2); also the maximum number of outstanding pairs
ADDR_W, 18, VRAM 32-bit word address width (1024x512 halfwords)

Ports:
clk  in  1  system clock
i_nrst  in  1  asynchronous active-low reset
i_reqValid  in  1  pixel-pair request valid
o_reqReady  out  1  request accepted when valid&ready
i_scrX_Mul2  in  10  X of left pixel (bit0 ignored)
i_scrY  in  9  Y of pair
i_needBG  in  1  1: fetch VRAM word; 0: no read, return zero background
o_memRead  out  1  read command, held until ack
o_memAdr  out  ADDR_W  word address = {i_scrY, i_scrX_Mul2[9:1]}
i_memAck  in  1  read command accepted this cycle
i_memDataValid  in  1  read data beat (in request order)
i_memData  in  32  {bit15_R,B_R,G_R,R_R, bit15_L,B_L,G_L,R_L}
o_bgValid  out  1  background pair available
i_bgReady  in  1  consumer pops pair when valid&ready
o_rBG_L,o_gBG_L,o_bBG_L  out  5 each  left background channels
o_rBG_R,o_gBG_R,o_bBG_R  out  5 each  right background channels
o_bgMskL,o_bgMskR  out  1 each  bit15 of left/right background pixel

Behaviour:
- Reset: o_reqReady=0 for the reset cycle, then follows its rule below. o_memRead=0, o_memAdr=0, o_bgValid=0, all colour/mask outputs 0, buffer empty, all pointers/counters 0.
- Result buffer: FIFO_DEPTH slots, each holding a 32-bit word and a done bit.
  - Allocation happens on request accept.
  - needBG=0 slot: written with 0 and done=1 immediately.
  - needBG=1 slot: done=0; its index is pushed into the pending-index FIFO (depth FIFO_DEPTH).
- Memory FSM, two states:
  - IDLE: on accepting a needBG=1 request, register the address and go to WAIT_ACK with o_memRead=1 the next cycle.
  - WAIT_ACK: hold o_memRead and o_memAdr stable until i_memAck. On ack, drop o_memRead the same edge and return to IDLE.
- o_reqReady = (count < FIFO_DEPTH) && (state == IDLE).
  - count is registered and excludes any same-cycle pop; there is no combinational path from i_bgReady.
  - Back-to-back needBG=1 requests therefore issue at most one read every 2 cycles.
  - needBG=0 requests are accepted every cycle while space exists.
- Data return: i_memDataValid writes i_memData to the slot at the head of the pending-index FIFO, sets done, and pops the index.
  - Beats arriving with the pending FIFO empty (stale after reset, or spurious) are dropped.
- Output:
  - o_bgValid = done bit of the head slot.
  - Outputs are taken directly from head slot storage: R=[4:0], G=[9:5], B=[14:10], mask=[15] for left; the same fields +16 for right.
  - Pop on o_bgValid&i_bgReady; head slot is cleared and done=0.
- Ordering: output order always equals request order, including mixed needBG.
  - A done needBG=0 slot behind an unfilled read waits.
- Simultaneous events:
  - Allocate and pop in the same cycle: count unchanged.
  - Data return to the head slot and pop in the same cycle cannot occur (pop needs done already set); the return sets done and valid shows next cycle.
  - Ack and new request in the same cycle: the request is not accepted (state ≠ IDLE).
- Latency: needBG=0 pair visible 1 cycle after accept. needBG=1 pair visible 1 cycle after its data beat.
- Reset mid-operation flushes everything; in-flight memory data afterward is dropped.
- Wrap-around: pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Shared GPU package holds:
  - bg pixel-pair struct (5-bit r,g,b + mask, L/R)
  - unpack function word->pair
  - VRAM word-address width constant
- One sub-module is natural: gpu_idx_fifo, a small synchronous index FIFO used for the pending-read slot indices.

Test Plan:
- Single needBG=1 at X_Mul2=0x0A6,Y=0x045: o_memAdr=0x08A53, hold 3 cycles w/o ack, stays stable. Return 0x8421_7FFF -> L r=g=b=31 mskL=0; R r=1,g=1,b=1,mskR=1.
- 4 needBG=0 requests back-to-back with i_bgReady=0 -> reqReady low after 4th; 4 zero pairs out in order on release.
- Mixed order: read(A), noBG, read(B); return B-data only after 5 cycles -> noBG pair held until A popped; output order A,0,B.
- Full buffer with pop+request same cycle -> request not accepted that cycle (reqReady=0), accepted next; no loss or duplication.
- Spurious i_memDataValid with nothing pending -> no output change, count unchanged.
- Reset asserted during WAIT_ACK with 2 slots full -> all outputs 0 immediately; later data beat dropped; normal request after reset works.
